// File: rtl/dlx_dest_scoreboard_pkg.sv
// Shared constants and the address-to-one-hot helper for the DLX destination path.
package dlx_dest_scoreboard_pkg;

  localparam int DLX_ADDR_W = 3;
  localparam int DLX_NREG   = 8;
  localparam logic [DLX_ADDR_W-1:0] DLX_R0 = 3'd0;

  // Plain one-hot decode; R0 masking and enable are applied by the caller.
  function automatic logic [DLX_NREG-1:0] dlx_onehot(input logic [DLX_ADDR_W-1:0] addr);
    logic [DLX_NREG-1:0] v;
    v = {{(DLX_NREG-1){1'b0}}, 1'b1} << addr;
    return v;
  endfunction

endpackage

// File: rtl/dlx_dest_scoreboard_if.sv
// Issue / write-back bus between decode, the scoreboard and the register file.
interface dlx_dest_scoreboard_if;
  import dlx_dest_scoreboard_pkg::*;

  logic                  issue_valid;
  logic [DLX_ADDR_W-1:0] issue_dest;
  logic [DLX_ADDR_W-1:0] src_a;
  logic [DLX_ADDR_W-1:0] src_b;
  logic                  stall;
  logic                  wb_valid;
  logic [DLX_ADDR_W-1:0] wb_dest;
  logic [DLX_NREG-1:0]   wb_we;
  logic [DLX_NREG-1:0]   busy;
  logic [DLX_ADDR_W:0]   pend_cnt;
  logic                  err_wb_idle;

  modport master (
    output issue_valid, issue_dest, src_a, src_b, wb_valid, wb_dest,
    input  stall, wb_we, busy, pend_cnt, err_wb_idle
  );

  modport slave (
    input  issue_valid, issue_dest, src_a, src_b, wb_valid, wb_dest,
    output stall, wb_we, busy, pend_cnt, err_wb_idle
  );

endinterface

// File: rtl/dlx_dest_decode.sv
// Combinational register-address decoder with enable; R0 never decodes.
module dlx_dest_decode
  import dlx_dest_scoreboard_pkg::*;
(
  input  logic                  en,
  input  logic [DLX_ADDR_W-1:0] addr,
  output logic [DLX_NREG-1:0]   onehot
);

  // One-hot select, suppressed when disabled or targeting R0
  always_comb begin
    onehot = '0;
    if (en && (addr != DLX_R0)) begin
      onehot = dlx_onehot(addr);
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/dlx_dest_scoreboard.sv
// Busy scoreboard for the 8-entry register file: RAW/WAW issue stall,
// registered one-hot write enables and an idle-write-back error flag.
module dlx_dest_scoreboard
  import dlx_dest_scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  dlx_dest_scoreboard_if.slave bus
);

  logic [DLX_NREG-1:0] busy_r;
  logic [DLX_NREG-1:0] wb_we_r;
  logic [DLX_ADDR_W:0] pend_cnt_r;
  logic                err_wb_idle_r;

  logic                stall_s;
  logic                accept_s;
  logic [DLX_NREG-1:0] set_s;
  logic [DLX_NREG-1:0] clr_s;
  logic [DLX_NREG-1:0] busy_nxt_s;
  logic                inc_s;
  logic                dec_s;
  logic                err_hit_s;

  function automatic logic hz(input logic [DLX_ADDR_W-1:0] r, input logic [DLX_NREG-1:0] b);
    return (r != DLX_R0) && b[r];
  endfunction

  // Hazard detection and next-state scoreboard vector
  always_comb begin
    stall_s  = bus.issue_valid &&
               (hz(bus.src_a, busy_r) || hz(bus.src_b, busy_r) || hz(bus.issue_dest, busy_r));
    accept_s = bus.issue_valid && !stall_s;
    // Set is applied after clear so a same-register issue keeps the entry busy.
    busy_nxt_s = (busy_r & ~clr_s) | set_s;
    inc_s      = |set_s;
    // Only clears of genuinely busy entries reduce the count, keeping it equal to popcount.
    dec_s      = |(clr_s & busy_r);
    err_hit_s  = bus.wb_valid && (bus.wb_dest != DLX_R0) && !busy_r[bus.wb_dest];
  end

  dlx_dest_decode u_set_dec (
    .en     (accept_s),
    .addr   (bus.issue_dest),
    .onehot (set_s)
  );

  dlx_dest_decode u_clr_dec (
    .en     (bus.wb_valid),
    .addr   (bus.wb_dest),
    .onehot (clr_s)
  );

  // Scoreboard, write-enable, counter and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r        <= '0;
      wb_we_r       <= '0;
      pend_cnt_r    <= '0;
      err_wb_idle_r <= 1'b0;
    end else begin
      busy_r        <= busy_nxt_s;
      wb_we_r       <= clr_s;
      pend_cnt_r    <= pend_cnt_r + {{DLX_ADDR_W{1'b0}}, inc_s} - {{DLX_ADDR_W{1'b0}}, dec_s};
      err_wb_idle_r <= err_wb_idle_r | err_hit_s;
    end
  end

  assign bus.stall       = stall_s;
  assign bus.busy        = busy_r;
  assign bus.wb_we       = wb_we_r;
  assign bus.pend_cnt    = pend_cnt_r;
  assign bus.err_wb_idle = err_wb_idle_r;

endmodule

// File: tb/tb_dlx_dest_scoreboard.sv
// Directed self-checking bench for dlx_dest_scoreboard.
module tb_dlx_dest_scoreboard;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dlx_dest_scoreboard_if sb_if ();

  dlx_dest_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [2:0] id, input logic [2:0] sa,
                       input logic [2:0] sb, input logic wv, input logic [2:0] wd);
    sb_if.issue_valid = iv;
    sb_if.issue_dest  = id;
    sb_if.src_a       = sa;
    sb_if.src_b       = sb;
    sb_if.wb_valid    = wv;
    sb_if.wb_dest     = wd;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] busy, input logic [3:0] cnt,
                           input logic [7:0] we, input logic err);
    chk({tag, "_busy"}, {24'd0, sb_if.busy}, {24'd0, busy});
    chk({tag, "_cnt"},  {28'd0, sb_if.pend_cnt}, {28'd0, cnt});
    chk({tag, "_we"},   {24'd0, sb_if.wb_we}, {24'd0, we});
    chk({tag, "_err"},  {31'd0, sb_if.err_wb_idle}, {31'd0, err});
  endtask

  initial begin
    logic [7:0] exp_we;
    logic [7:0] exp_busy;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    cyc();
    cyc();

    // 1: write-back during reset is ignored
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd5);
    cyc();
    reset = 1'b0;
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    chk_state("t1_reset", 8'h00, 4'd0, 8'h00, 1'b0);
    chk("t1_stall", {31'd0, sb_if.stall}, 32'd0);

    // 2: RAW stall, no same-cycle bypass, held issue accepted after clear
    drive(1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 3'd0);
    chk("t2_issue3_stall", {31'd0, sb_if.stall}, 32'd0);
    cyc();
    chk_state("t2_after_issue3", 8'h08, 4'd1, 8'h00, 1'b0);
    drive(1'b1, 3'd1, 3'd3, 3'd0, 1'b0, 3'd0);
    chk("t2_raw_stall", {31'd0, sb_if.stall}, 32'd1);
    cyc();
    chk_state("t2_held", 8'h08, 4'd1, 8'h00, 1'b0);
    drive(1'b1, 3'd1, 3'd3, 3'd0, 1'b1, 3'd3);
    chk("t2_no_bypass", {31'd0, sb_if.stall}, 32'd1);
    cyc();
    drive(1'b1, 3'd1, 3'd3, 3'd0, 1'b0, 3'd0);
    chk_state("t2_wb3", 8'h00, 4'd0, 8'h08, 1'b0);
    chk("t2_stall_drop", {31'd0, sb_if.stall}, 32'd0);
    cyc();
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd1);
    chk_state("t2_accepted", 8'h02, 4'd1, 8'h00, 1'b0);
    cyc();
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    chk_state("t2_wb1", 8'h00, 4'd0, 8'h02, 1'b0);

    // 3: R0 never stalls, never goes busy, write-back to R0 is silent
    drive(1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    chk("t3_r0_stall", {31'd0, sb_if.stall}, 32'd0);
    cyc();
    chk_state("t3_r0_issue", 8'h00, 4'd0, 8'h00, 1'b0);
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd0);
    cyc();
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    chk_state("t3_r0_wb", 8'h00, 4'd0, 8'h00, 1'b0);

    // 4: simultaneous issue and write-back on different registers
    drive(1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 3'd0);
    cyc();
    drive(1'b1, 3'd6, 3'd0, 3'd0, 1'b1, 3'd2);
    chk_state("t4_busy2", 8'h04, 4'd1, 8'h00, 1'b0);
    chk("t4_stall", {31'd0, sb_if.stall}, 32'd0);
    cyc();
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd6);
    chk_state("t4_swap", 8'h40, 4'd1, 8'h04, 1'b0);
    cyc();
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    chk_state("t4_clear6", 8'h00, 4'd0, 8'h40, 1'b0);

    // 5: idle write-back sets the sticky error; same-register issue+wb keeps busy
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd4);
    cyc();
    drive(1'b1, 3'd7, 3'd0, 3'd0, 1'b1, 3'd7);
    chk_state("t5_err", 8'h00, 4'd0, 8'h10, 1'b1);
    chk("t5_same_stall", {31'd0, sb_if.stall}, 32'd0);
    cyc();
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd7);
    chk_state("t5_same_reg", 8'h80, 4'd1, 8'h80, 1'b1);
    cyc();
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    chk_state("t5_sticky", 8'h00, 4'd0, 8'h80, 1'b1);

    // 6: fill all seven registers, WAW stall, then drain
    exp_busy = 8'h00;
    for (int d = 1; d <= 7; d++) begin
      drive(1'b1, 3'(d), 3'd0, 3'd0, 1'b0, 3'd0);
      chk($sformatf("t6_fill_stall%0d", d), {31'd0, sb_if.stall}, 32'd0);
      cyc();
      exp_we = 8'd1 << d;
      exp_busy = exp_busy | exp_we;
      chk($sformatf("t6_fill_busy%0d", d), {24'd0, sb_if.busy}, {24'd0, exp_busy});
      chk($sformatf("t6_fill_cnt%0d", d), {28'd0, sb_if.pend_cnt}, d);
    end
    drive(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 3'd0);
    chk("t6_waw_stall", {31'd0, sb_if.stall}, 32'd1);
    cyc();
    chk_state("t6_full", 8'hFE, 4'd7, 8'h00, 1'b1);
    for (int d = 1; d <= 7; d++) begin
      drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'(d));
      cyc();
      exp_we = 8'd1 << d;
      chk($sformatf("t6_drain_we%0d", d), {24'd0, sb_if.wb_we}, {24'd0, exp_we});
      chk($sformatf("t6_drain_cnt%0d", d), {28'd0, sb_if.pend_cnt}, 7 - d);
    end
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    cyc();
    chk_state("t6_empty", 8'h00, 4'd0, 8'h00, 1'b1);

    // Reset mid-operation drops pending entries and clears the error
    drive(1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 3'd0);
    cyc();
    chk_state("t7_pre", 8'h08, 4'd1, 8'h00, 1'b1);
    reset = 1'b1;
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd3);
    cyc();
    reset = 1'b0;
    drive(1'b1, 3'd1, 3'd3, 3'd0, 1'b0, 3'd0);
    chk_state("t7_reset", 8'h00, 4'd0, 8'h00, 1'b0);
    chk("t7_stall", {31'd0, sb_if.stall}, 32'd0);
    cyc();
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    chk_state("t7_after", 8'h02, 4'd1, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
